// File: rtl/face_pkg.sv
// Shared record layout and helpers for the face detection result queue.
// One record is either a detection or an end-of-frame summary of that frame.
package face_pkg;

  localparam int COORD_W    = 32;
  localparam int PYR_W      = 4;
  localparam int FRAME_ID_W = 4;

  typedef struct packed {
    logic                  eof;
    logic [FRAME_ID_W-1:0] frame_id;
    logic [PYR_W-1:0]      pyr;
    logic [COORD_W-1:0]    row;
    logic [COORD_W-1:0]    col;
  } face_rec_t;

  localparam int REC_W = $bits(face_rec_t);

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v,
                                                 input logic en);
    return (en && (v != {COORD_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: head word is always on rdata_o.
// Pushes beyond capacity and pops from empty are ignored.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_i && (count_q != FULL);
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the consumer gates stale data with the count.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/face_result_fifo.sv
// Queues face detections and per-frame end-of-frame summaries for a host drain.
// The last queue slot is held back so a closing EOF record always has room.
module face_result_fifo
  import face_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          face_coords_ready,
  input  logic [1:0][COORD_W-1:0]       face_coords,
  input  logic [PYR_W-1:0]              pyramid_number,
  input  logic                          vj_pipeline_done,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [COORD_W-1:0]            out_row,
  output logic [COORD_W-1:0]            out_col,
  output logic [PYR_W-1:0]              out_pyramid,
  output logic                          out_eof,
  output logic [FRAME_ID_W-1:0]         out_frame_id,
  output logic [$clog2(DEPTH):0]        fill_count,
  output logic [DROP_W-1:0]             drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic                  done_q;
  logic                  eof_pending_q, eof_pending_d;
  logic [FRAME_ID_W-1:0] frame_tag_q, frame_tag_d;
  logic [COORD_W-1:0]    frame_acc_q, frame_acc_d;
  logic [COORD_W-1:0]    frame_drop_q, frame_drop_d;
  logic [DROP_W-1:0]     drop_count_q, drop_count_d;

  logic                  done_edge, eof_wr, det_wr, det_drop, push, pop;
  logic [COORD_W-1:0]    drop_closing;
  logic [CW-1:0]         fill;
  face_rec_t             wr_rec, head;
  logic [REC_W-1:0]      head_bits;

  always_comb begin
    done_edge    = vj_pipeline_done && !done_q;
    eof_wr       = eof_pending_q && (fill < FULL);
    det_wr       = face_coords_ready && !eof_wr && (fill < LAST);
    det_drop     = face_coords_ready && !det_wr;
    // A detection lost to the EOF write still belongs to the closing frame.
    drop_closing = sat_inc(frame_drop_q, det_drop);
    push         = eof_wr || det_wr;
    pop          = out_ready && (fill != '0);

    wr_rec = '0;
    if (eof_wr) begin
      wr_rec.eof      = 1'b1;
      wr_rec.frame_id = frame_tag_q;
      wr_rec.pyr      = '0;
      wr_rec.row      = frame_acc_q;
      wr_rec.col      = drop_closing;
    end else begin
      wr_rec.eof      = 1'b0;
      wr_rec.frame_id = frame_tag_q;
      wr_rec.pyr      = pyramid_number;
      wr_rec.row      = face_coords[0];
      wr_rec.col      = face_coords[1];
    end

    eof_pending_d = eof_wr ? 1'b0 : (eof_pending_q || done_edge);
    if (eof_wr) begin
      frame_tag_d  = frame_tag_q + 1'b1;
      frame_acc_d  = '0;
      frame_drop_d = '0;
    end else begin
      frame_tag_d  = frame_tag_q;
      frame_acc_d  = sat_inc(frame_acc_q, det_wr);
      frame_drop_d = drop_closing;
    end
    drop_count_d = (det_drop && (drop_count_q != {DROP_W{1'b1}}))
                   ? drop_count_q + 1'b1 : drop_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q        <= 1'b0;
      eof_pending_q <= 1'b0;
      frame_tag_q   <= '0;
      frame_acc_q   <= '0;
      frame_drop_q  <= '0;
      drop_count_q  <= '0;
    end else begin
      done_q        <= vj_pipeline_done;
      eof_pending_q <= eof_pending_d;
      frame_tag_q   <= frame_tag_d;
      frame_acc_q   <= frame_acc_d;
      frame_drop_q  <= frame_drop_d;
      drop_count_q  <= drop_count_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (wr_rec),
    .pop_i   (pop),
    .rdata_o (head_bits),
    .count_o (fill)
  );

  // Head fields read zero whenever the queue is empty, including after reset.
  always_comb begin
    head         = face_rec_t'(head_bits);
    out_valid    = (fill != '0);
    out_row      = out_valid ? head.row      : '0;
    out_col      = out_valid ? head.col      : '0;
    out_pyramid  = out_valid ? head.pyr      : '0;
    out_eof      = out_valid ? head.eof      : 1'b0;
    out_frame_id = out_valid ? head.frame_id : '0;
    fill_count   = fill;
    drop_count   = drop_count_q;
  end

endmodule

// File: tb/tb_face_result_fifo.sv
// Directed bench for face_result_fifo: reset, single frame, overflow, EOF
// collisions, streaming, mid-frame reset and frame tag wrap.
module tb_face_result_fifo;
  import face_pkg::*;

  logic                    clock;
  logic                    reset;
  logic                    face_coords_ready;
  logic [1:0][COORD_W-1:0] face_coords;
  logic [PYR_W-1:0]        pyramid_number;
  logic                    vj_pipeline_done;
  logic                    out_ready;
  logic                    out_valid;
  logic [COORD_W-1:0]      out_row;
  logic [COORD_W-1:0]      out_col;
  logic [PYR_W-1:0]        out_pyramid;
  logic                    out_eof;
  logic [FRAME_ID_W-1:0]   out_frame_id;
  logic [4:0]              fill_count;
  logic [15:0]             drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  face_result_fifo #(.DEPTH(16), .DROP_W(16)) dut (
    .clock             (clock),
    .reset             (reset),
    .face_coords_ready (face_coords_ready),
    .face_coords       (face_coords),
    .pyramid_number    (pyramid_number),
    .vj_pipeline_done  (vj_pipeline_done),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_row           (out_row),
    .out_col           (out_col),
    .out_pyramid       (out_pyramid),
    .out_eof           (out_eof),
    .out_frame_id      (out_frame_id),
    .fill_count        (fill_count),
    .drop_count        (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic eof, input logic [3:0] fid,
                          input logic [3:0] pyr, input logic [31:0] row,
                          input logic [31:0] col);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".eof"},   64'(out_eof), 64'(eof));
    chk({tag, ".fid"},   64'(out_frame_id), 64'(fid));
    chk({tag, ".pyr"},   64'(out_pyramid), 64'(pyr));
    chk({tag, ".row"},   64'(out_row), 64'(row));
    chk({tag, ".col"},   64'(out_col), 64'(col));
  endtask

  task automatic drive_det(input logic en, input logic [31:0] r, input logic [31:0] c,
                           input logic [3:0] p);
    face_coords_ready = en;
    face_coords[0]    = r;
    face_coords[1]    = c;
    pyramid_number    = p;
  endtask

  initial begin
    reset            = 1'b1;
    out_ready        = 1'b0;
    vj_pipeline_done = 1'b0;
    drive_det(1'b0, 32'd0, 32'd0, 4'd0);
    step();
    step();
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 20; i++) begin
      chk("idle.valid", 64'(out_valid), 64'd0);
      chk("idle.fill",  64'(fill_count), 64'd0);
      chk("idle.drop",  64'(drop_count), 64'd0);
      step();
    end

    // Single detection then done (frame 0)
    out_ready = 1'b1;
    drive_det(1'b1, 32'd12, 32'd40, 4'd3);
    step();
    drive_det(1'b0, 32'd0, 32'd0, 4'd0);
    chk_head("single.rec", 1'b0, 4'd0, 4'd3, 32'd12, 32'd40);
    step();
    chk("single.popped", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    step();
    step();
    step();
    vj_pipeline_done = 1'b1;
    step();
    chk("single.eof_latency", 64'(out_valid), 64'd0);
    step();
    chk_head("single.eof", 1'b1, 4'd0, 4'd0, 32'd1, 32'd0);
    chk("single.fill", 64'(fill_count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vj_pipeline_done = 1'b0;
    chk("single.empty", 64'(fill_count), 64'd0);
    step();

    // Overflow (frame 1): 20 detections into 15 usable slots
    for (int i = 0; i < 20; i++) begin
      drive_det(1'b1, 32'(i), 32'(100 + i), 4'd2);
      step();
    end
    drive_det(1'b0, 32'd0, 32'd0, 4'd0);
    chk("ovf.fill", 64'(fill_count), 64'd15);
    chk("ovf.drop", 64'(drop_count), 64'd5);
    vj_pipeline_done = 1'b1;
    step();
    step();
    chk("ovf.fill_eof", 64'(fill_count), 64'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk_head($sformatf("ovf.rec%0d", i), 1'b0, 4'd1, 4'd2, 32'(i), 32'(100 + i));
      step();
    end
    chk_head("ovf.eof", 1'b1, 4'd1, 4'd0, 32'd15, 32'd5);
    step();
    chk("ovf.drained", 64'(fill_count), 64'd0);
    out_ready = 1'b0;
    vj_pipeline_done = 1'b0;
    step();

    // Done edge and detection together (frame 2): detection lands first
    drive_det(1'b1, 32'd7, 32'd8, 4'd1);
    vj_pipeline_done = 1'b1;
    step();
    drive_det(1'b0, 32'd0, 32'd0, 4'd0);
    step();
    chk("simA.fill", 64'(fill_count), 64'd2);
    out_ready = 1'b1;
    chk_head("simA.rec", 1'b0, 4'd2, 4'd1, 32'd7, 32'd8);
    step();
    chk_head("simA.eof", 1'b1, 4'd2, 4'd0, 32'd1, 32'd0);
    step();
    out_ready = 1'b0;
    vj_pipeline_done = 1'b0;
    step();

    // Detection on the EOF write cycle (frame 3): dropped into closing frame
    vj_pipeline_done = 1'b1;
    step();
    drive_det(1'b1, 32'd9, 32'd9, 4'd1);
    step();
    drive_det(1'b0, 32'd0, 32'd0, 4'd0);
    chk("simB.fill", 64'(fill_count), 64'd1);
    chk("simB.drop", 64'(drop_count), 64'd6);
    chk_head("simB.eof", 1'b1, 4'd3, 4'd0, 32'd0, 32'd1);
    out_ready = 1'b1;
    step();
    chk("simB.empty", 64'(fill_count), 64'd0);
    vj_pipeline_done = 1'b0;
    step();

    // Streaming push+pop (frame 4)
    for (int i = 0; i < 100; i++) begin
      drive_det(1'b1, 32'(i), 32'(3 * i), 4'(i));
      step();
      chk("stream.fill", 64'(fill_count), 64'd1);
      chk("stream.row",  64'(out_row), 64'(i));
      chk("stream.fid",  64'(out_frame_id), 64'd4);
    end
    drive_det(1'b0, 32'd0, 32'd0, 4'd0);
    step();
    chk("stream.empty", 64'(fill_count), 64'd0);
    chk("stream.drop",  64'(drop_count), 64'd6);

    // Reset mid-frame with 7 queued
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_det(1'b1, 32'(50 + i), 32'd1, 4'd5);
      step();
    end
    drive_det(1'b0, 32'd0, 32'd0, 4'd0);
    chk("rst.fill_before", 64'(fill_count), 64'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.fill",  64'(fill_count), 64'd0);
    chk("rst.drop",  64'(drop_count), 64'd0);
    chk("rst.row",   64'(out_row), 64'd0);
    chk("rst.fid",   64'(out_frame_id), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst.no_eof", 64'(out_valid), 64'd0);
    end
    drive_det(1'b1, 32'd5, 32'd6, 4'd7);
    step();
    drive_det(1'b0, 32'd0, 32'd0, 4'd0);
    chk_head("rst.newrec", 1'b0, 4'd0, 4'd7, 32'd5, 32'd6);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("rst.empty", 64'(fill_count), 64'd0);

    // Frame tag wrap across 17 frames
    for (int f = 0; f < 17; f++) begin
      vj_pipeline_done = 1'b1;
      step();
      vj_pipeline_done = 1'b0;
      step();
      chk_head($sformatf("wrap.eof%0d", f), 1'b1, 4'(f), 4'd0,
               (f == 0) ? 32'd1 : 32'd0, 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("wrap.empty", 64'(fill_count), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
